// File: rtl/lvt_pkg.sv
// Shared definitions for the live-value-table memory and its read/write
// front ends: default widths, address/data types and the write-snoop bundle.
package lvt_pkg;

  localparam int LVT_ADDR_W = 7;
  localparam int LVT_DATA_W = 32;

  typedef logic [LVT_ADDR_W-1:0] addr_t;
  typedef logic [LVT_DATA_W-1:0] data_t;

  // One write port as seen by anything that snoops it.
  typedef struct packed {
    logic  en;
    addr_t addr;
    data_t data;
  } wr_snoop_t;

endpackage

// File: rtl/lvt_rsp_fifo.sv
// First-word-fall-through FIFO with an occupancy count. The head entry is
// visible on head_data whenever empty is low; pop consumes it. Push and pop
// in the same cycle are legal at any occupancy, including full.
module lvt_rsp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = store[rd_ptr];

  // Data storage: written at the tail, no reset needed since reads are
  // qualified by the count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointer and count bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A push into a full FIFO without a matching pop loses data.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !do_pop));

endmodule

// File: rtl/lvt_read_port.sv
// Read-side front end of the 2W/1R live-value-table memory. Issues client
// reads straight to the memory read port, snoops both write ports so a read
// colliding with a write returns the new data, and queues responses in order.
//
// Handshakes: a request transfers on a cycle where req_valid && req_ready;
// a response transfers on a cycle where rsp_valid && rsp_ready. req_ready
// depends only on registered state (never on req_valid or rsp_ready), and
// rsp_valid/rsp_data stay stable until the response transfers.
module lvt_read_port
  import lvt_pkg::*;
#(
  parameter int ADDR_W    = LVT_ADDR_W,
  parameter int DATA_W    = LVT_DATA_W,
  parameter int RSP_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_W-1:0]           req_addr,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           mem_rd_addr,
  input  logic [DATA_W-1:0]           mem_rd_data,
  input  logic                        wr0_en,
  input  logic [ADDR_W-1:0]           wr0_addr,
  input  logic [DATA_W-1:0]           wr0_data,
  input  logic                        wr1_en,
  input  logic [ADDR_W-1:0]           wr1_addr,
  input  logic [DATA_W-1:0]           wr1_data,
  output logic [$clog2(RSP_DEPTH):0]  occupancy
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;

  logic              inflight;
  logic              bypass;
  logic [DATA_W-1:0] bypass_data;
  logic              hit0;
  logic              hit1;
  logic [DATA_W-1:0] capture_data;
  logic [DATA_W-1:0] head_data;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;

  // Credit: every FIFO entry and every read still in the memory pipe holds
  // one slot, so an accepted read always has somewhere to land.
  assign occupancy = fifo_count + CW'(inflight);
  assign req_ready = (occupancy < CW'(RSP_DEPTH));

  // Issue is purely combinational; the address is parked at zero when idle
  // and the port is kept quiet while reset is asserted.
  assign mem_rd_en   = req_valid && req_ready && !rst;
  assign mem_rd_addr = mem_rd_en ? req_addr : '0;

  // Same-cycle write collisions; port 1 has priority when both hit.
  assign hit0 = wr0_en && (wr0_addr == req_addr);
  assign hit1 = wr1_en && (wr1_addr == req_addr);

  // Track the outstanding read and latch any colliding write data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight    <= 1'b0;
      bypass      <= 1'b0;
      bypass_data <= '0;
    end else begin
      inflight <= mem_rd_en;
      if (mem_rd_en) begin
        bypass      <= hit0 || hit1;
        bypass_data <= hit1 ? wr1_data : wr0_data;
      end else begin
        bypass <= 1'b0;
      end
    end
  end

  assign capture_data = bypass ? bypass_data : mem_rd_data;
  assign pop          = rsp_valid && rsp_ready;

  lvt_rsp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (capture_data),
    .pop       (pop),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Stale storage never leaks out: data reads as zero while nothing is valid.
  assign rsp_valid = !fifo_empty;
  assign rsp_data  = rsp_valid ? head_data : '0;

  // The credit scheme must keep a returning read from meeting a full FIFO.
  a_credit_holds: assert property (@(posedge clk) disable iff (rst)
    !(inflight && fifo_full && !pop));

endmodule

// File: tb/tb_lvt_read_port.sv
// Directed bench for lvt_read_port with a behavioural 128-word memory that
// returns the pre-write value on a same-cycle read/write.
module tb_lvt_read_port;
  import lvt_pkg::*;

  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int OW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  wr_snoop_t     wr0 = '0;
  wr_snoop_t     wr1 = '0;
  logic [OW-1:0] occupancy;

  lvt_read_port #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .wr0_en      (wr0.en),
    .wr0_addr    (wr0.addr),
    .wr0_data    (wr0.data),
    .wr1_en      (wr1.en),
    .wr1_addr    (wr1.addr),
    .wr1_data    (wr1.data),
    .occupancy   (occupancy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  // Word i holds 0xA000_0000+i, except word 5 = 0xDEADBEEF.
  logic [DW-1:0] mem [128];
  logic          mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hA000_0000 + 32'(i);
      mem[5]        <= 32'hDEAD_BEEF;
      mem_init_done <= 1'b1;
    end else begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      if (wr0.en)    mem[wr0.addr] <= wr0.data;
      if (wr1.en)    mem[wr1.addr] <= wr1.data;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            pop_cyc_q[$];

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      pop_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else                   check_eq("rsp_data_order", rsp_data, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  int acc_cyc;

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] e, output int waits);
    waits     = 0;
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    while (!req_ready && waits < 100) begin
      @(posedge clk); #2;
      waits++;
    end
    if (!req_ready) begin
      check_eq("req_timeout", 32'(req_ready), 32'd1);
    end else begin
      check_eq("rd_en_at_issue", 32'(mem_rd_en), 32'd1);
      check_eq("rd_addr_at_issue", 32'(mem_rd_addr), 32'(a));
      acc_cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"},   32'(req_ready),   32'd1);
    check_eq({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    check_eq({tag, "_rsp_data"},    rsp_data,         32'd0);
    check_eq({tag, "_mem_rd_en"},   32'(mem_rd_en),   32'd0);
    check_eq({tag, "_mem_rd_addr"}, 32'(mem_rd_addr), 32'd0);
    check_eq({tag, "_occupancy"},   32'(occupancy),   32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w;
    int tot_w;
    int idx;
    int base;
    int acc0;

    // reset
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(1);

    // 1. basic read, latency 2, single-cycle rd_en
    send(7'd5, 32'hDEAD_BEEF, w);
    #1;
    check_eq("basic_rd_en_pulse", 32'(mem_rd_en), 32'd0);
    check_eq("basic_t1_valid",    32'(rsp_valid), 32'd0);
    check_eq("basic_t1_occ",      32'(occupancy), 32'd1);
    @(posedge clk); #1;
    check_eq("basic_t2_valid",    32'(rsp_valid), 32'd1);
    check_eq("basic_t2_data",     rsp_data,       32'hDEAD_BEEF);
    drain();

    // 2. same-cycle collisions on addr 9
    wr0 = '{en: 1'b1, addr: 7'd9, data: 32'h11};
    wr1 = '{en: 1'b1, addr: 7'd9, data: 32'h22};
    send(7'd9, 32'h22, w);
    wr0 = '0;
    wr1 = '0;
    wr0 = '{en: 1'b1, addr: 7'd9, data: 32'h11};
    send(7'd9, 32'h11, w);
    wr0 = '0;
    // wr1 alone, different-address wr0 must not interfere
    wr0 = '{en: 1'b1, addr: 7'd10, data: 32'h77};
    wr1 = '{en: 1'b1, addr: 7'd9,  data: 32'h44};
    send(7'd9, 32'h44, w);
    wr0 = '0;
    wr1 = '0;
    drain();

    // 3. late write is not seen; the following read is
    wr0 = '{en: 1'b1, addr: 7'd9, data: 32'h55};
    idle(1);
    wr0 = '0;
    send(7'd9, 32'h55, w);
    wr0 = '{en: 1'b1, addr: 7'd9, data: 32'h33};
    idle(1);
    wr0 = '0;
    send(7'd9, 32'h33, w);
    drain();

    // 4. back-pressure: stream addrs 20.. with rsp_ready low
    rsp_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      req_valid = 1'b1;
      req_addr  = 7'(20 + idx);
      #1;
      if (req_ready) begin
        exp_q.push_back(32'hA000_0000 + 32'(20 + idx));
        idx++;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    #1;
    check_eq("bp_accepted",  32'(idx),       32'd4);
    check_eq("bp_req_ready", 32'(req_ready), 32'd0);
    check_eq("bp_occupancy", 32'(occupancy), 32'd4);
    check_eq("bp_head",      rsp_data,       32'hA000_0014);
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_ready_same_cycle", 32'(req_ready), 32'd0);
    @(posedge clk); #2;
    check_eq("bp_ready_after_pop",  32'(req_ready), 32'd1);
    check_eq("bp_occ_after_pop",    32'(occupancy), 32'd3);
    @(posedge clk); #1;
    drain();

    // 5. full throughput: 16 back-to-back reads
    base  = pop_cyc_q.size();
    tot_w = 0;
    acc0  = 0;
    for (int i = 0; i < 16; i++) begin
      send(7'(32 + i), 32'hA000_0020 + 32'(i), w);
      tot_w += w;
      if (i == 0) acc0 = acc_cyc;
    end
    drain();
    check_eq("tp_no_stall",   32'(tot_w), 32'd0);
    check_eq("tp_pop_count",  32'(pop_cyc_q.size() - base), 32'd16);
    if (pop_cyc_q.size() - base == 16) begin
      check_eq("tp_first_rsp", 32'(pop_cyc_q[base]), 32'(acc0 + 2));
      check_eq("tp_contiguous", 32'(pop_cyc_q[base + 15] - pop_cyc_q[base]), 32'd15);
    end

    // 6. reset with 3 queued responses and one read in flight
    rsp_ready = 1'b0;
    send(7'd40, 32'hA000_0028, w);
    send(7'd41, 32'hA000_0029, w);
    send(7'd42, 32'hA000_002A, w);
    send(7'd43, 32'hA000_002B, w);
    check_eq("pre_rst_occ", 32'(occupancy), 32'd4);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    idle(2);
    rst       = 1'b0;
    rsp_ready = 1'b1;
    base      = pop_cyc_q.size();
    idle(5);
    check_eq("post_rst_no_rsp",   32'(pop_cyc_q.size() - base), 32'd0);
    check_eq("post_rst_occ",      32'(occupancy), 32'd0);
    send(7'd5, 32'hDEAD_BEEF, w);
    #1;
    check_eq("post_rst_t1_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("post_rst_t2_valid", 32'(rsp_valid), 32'd1);
    check_eq("post_rst_t2_data",  rsp_data,       32'hDEAD_BEEF);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
